// File: rtl/nco_ctl.sv
// Numerically controlled oscillator control path: phase accumulator with
// double-buffered frequency word, optional LFSR phase dither, cosine/sine
// ROM address generation and a valid pipeline matching the ROM read latency.
module nco_ctl #(
  parameter int ROMLAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fw,
  input  logic        fw_ld,
  output logic        fw_ack,
  input  logic [9:0]  ph_off,
  input  logic        sync,
  input  logic        en,
  input  logic        dith_en,
  output logic [9:0]  aa,
  output logic [9:0]  ab,
  input  logic [17:0] da,
  input  logic [17:0] db,
  output logic [17:0] cos,
  output logic [17:0] sin,
  output logic        vld
);

  logic [31:0]     r_acc;
  logic [31:0]     r_fwa;
  logic [31:0]     r_fwp;
  logic            r_pf;
  logic            r_fw_ack;
  logic [15:0]     r_lfsr;
  logic [9:0]      r_ab;
  logic [9:0]      r_aa;
  logic [ROMLAT:0] r_vpipe;
  logic [17:0]     r_cos;
  logic [17:0]     r_sin;
  logic            r_vld;

  logic            w_xfer;
  logic [31:0]     w_inc;
  logic [31:0]     w_dith;
  logic [31:0]     w_phase;
  logic [9:0]      w_ab_next;
  logic [9:0]      w_aa_next;
  logic            w_lfsr_fb;

  // A pending word becomes active on an advance cycle, unless a fresh load
  // arrives in the same cycle; the fresh load then only refreshes the pending
  // word and the transfer waits for the next advance.
  assign w_xfer    = en & r_pf & ~fw_ld;
  // The transferring word is used immediately in that cycle's add.
  assign w_inc     = w_xfer ? r_fwp : r_fwa;
  // Dither lives entirely below bit 22, so it can move the ROM address by at
  // most one step.
  assign w_dith    = dith_en ? {10'b0, r_lfsr, 6'b0} : 32'd0;
  // Phase is formed from the accumulator value before this cycle's update.
  assign w_phase   = r_acc + w_dith;
  assign w_ab_next = w_phase[31:22] + ph_off;
  // Cosine address leads the sine address by a quarter turn.
  assign w_aa_next = w_ab_next + 10'd256;
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Frequency word double buffer and activation acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwa    <= 32'd0;
      r_fwp    <= 32'd0;
      r_pf     <= 1'b0;
      r_fw_ack <= 1'b0;
    end else begin
      r_fw_ack <= w_xfer;
      if (fw_ld) begin
        r_fwp <= fw;
        r_pf  <= 1'b1;
      end else if (w_xfer) begin
        r_fwa <= r_fwp;
        r_pf  <= 1'b0;
      end
    end
  end

  // Phase accumulator; sync clears it even on an advance cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= 32'd0;
    end else if (sync) begin
      r_acc <= 32'd0;
    end else if (en) begin
      r_acc <= r_acc + w_inc;
    end
  end

  // Dither LFSR and ROM address registers advance once per issued sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
      r_ab   <= 10'd0;
      r_aa   <= 10'd256;
    end else if (en) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      r_ab   <= w_ab_next;
      r_aa   <= w_aa_next;
    end
  end

  // Valid token per issued sample, aligned with the ROM data return.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= en;
      for (int i = 1; i <= ROMLAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
    end
  end

  // Output capture: samples are latched only when their token reaches the
  // last stage; otherwise the last sample is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cos <= 18'd0;
      r_sin <= 18'd0;
      r_vld <= 1'b0;
    end else if (r_vpipe[ROMLAT]) begin
      r_cos <= da;
      r_sin <= db;
      r_vld <= 1'b1;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign fw_ack = r_fw_ack;
  assign ab     = r_ab;
  assign aa     = r_aa;
  assign cos    = r_cos;
  assign sin    = r_sin;
  assign vld    = r_vld;

endmodule
